// File: rtl/ext_irq_source_pkg.sv
// Shared definitions for the memory-mapped external interrupt source:
// default addresses, config word offsets, CTRL bit positions and FSM encodings.
package ext_irq_source_pkg;

    localparam logic [31:0] ACK_ADDR_DEF = 32'h0000_7F20;
    localparam logic [31:0] CFG_BASE_DEF = 32'h0000_7F30;

    localparam logic [31:0] OFF_CTRL   = 32'h0;
    localparam logic [31:0] OFF_PERIOD = 32'h4;
    localparam logic [31:0] OFF_COUNT  = 32'h8;
    localparam logic [31:0] OFF_STAT   = 32'hC;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_FIRE = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CNT  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/ext_irq_source_period_counter.sv
// Period counter: loads PERIOD, counts down while running and pulses expire
// in the cycle COUNT==1; on expiry it reloads (periodic) or parks at 0.
module ext_irq_source_period_counter (
    input  logic        gclk,
    input  logic        grst_n,
    input  logic        clear,
    input  logic        load,
    input  logic        run,
    input  logic        reload,
    input  logic [31:0] period,
    output logic [31:0] count,
    output logic        expire
);

    assign expire = run && (count == 32'd1);

    always_ff @(posedge gclk) begin
        if (!grst_n || clear) begin
            count <= '0;
        end else if (load) begin
            count <= period;
        end else if (expire) begin
            count <= reload ? period : 32'd0;
        end else if (run && (count != '0)) begin
            count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/ext_irq_source.sv
// External interrupt source: raises irq after a programmable countdown and
// holds it until the CPU stores to the ack address.
module ext_irq_source
    import ext_irq_source_pkg::*;
#(
    parameter logic [31:0] ACK_ADDR = ACK_ADDR_DEF,
    parameter logic [31:0] CFG_BASE = CFG_BASE_DEF,
    parameter int          MISS_W   = 8
) (
    input  logic        gclk,
    input  logic        grst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t            state;
    logic              en, mode;
    logic [31:0]       period, count;
    logic [MISS_W-1:0] miss;
    logic              cfg_wr, ctrl_wr, period_wr, ack;
    logic              en_next, fire, stop, load, run, expire;

    assign cfg_wr    = we && (byteen == 4'hF);
    assign ctrl_wr   = cfg_wr && (addr == CFG_BASE + OFF_CTRL);
    assign period_wr = cfg_wr && (addr == CFG_BASE + OFF_PERIOD);
    assign ack       = we && (byteen != 4'h0) && (addr == ACK_ADDR);

    // Loading on the CTRL write edge itself makes irq land PERIOD edges later.
    assign en_next = ctrl_wr ? wdata[CTRL_EN] : en;
    assign fire    = ctrl_wr && wdata[CTRL_EN] && wdata[CTRL_FIRE];
    assign stop    = ctrl_wr && !wdata[CTRL_EN];
    assign run     = (state != ST_IDLE);
    assign load    = (state == ST_IDLE) && en_next && (period != '0);

    ext_irq_source_period_counter u_cnt (
        .gclk   (gclk),
        .grst_n (grst_n),
        .clear  (stop),
        .load   (load),
        .run    (run),
        .reload (mode),
        .period (period),
        .count  (count),
        .expire (expire)
    );

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            state  <= ST_IDLE;
            irq    <= 1'b0;
            en     <= 1'b0;
            mode   <= 1'b0;
            period <= '0;
            miss   <= '0;
        end else begin
            if (period_wr) period <= wdata;
            if (ctrl_wr) begin
                en   <= wdata[CTRL_EN];
                mode <= wdata[CTRL_MODE];
                if (wdata[CTRL_EN] && !en) miss <= '0;
            end
            if (stop) begin
                state <= ST_IDLE;
                irq   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fire) begin
                            state <= ST_PEND;
                            irq   <= 1'b1;
                        end else if (load) begin
                            state <= ST_CNT;
                        end
                    end
                    ST_CNT: begin
                        if (fire || expire) begin
                            state <= ST_PEND;
                            irq   <= 1'b1;
                        end
                    end
                    ST_PEND: begin
                        // A new event outranks a same-cycle ack and is not a miss then.
                        if (fire || expire) begin
                            if (!ack && (miss != '1)) miss <= miss + 1'b1;
                        end else if (ack) begin
                            irq <= 1'b0;
                            if (mode) begin
                                state <= ST_CNT;
                            end else begin
                                state <= ST_IDLE;
                                en    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        irq   <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == CFG_BASE + OFF_CTRL) begin
            rdata[CTRL_EN]   = en;
            rdata[CTRL_MODE] = mode;
        end else if (addr == CFG_BASE + OFF_PERIOD) begin
            rdata = period;
        end else if (addr == CFG_BASE + OFF_COUNT) begin
            rdata = count;
        end else if (addr == CFG_BASE + OFF_STAT) begin
            rdata[8 +: MISS_W] = miss;
            rdata[0]           = irq;
        end
    end

endmodule
